// File: rtl/mem_stage.sv
// Memory stage: turns LOAD/STORE instructions from execute into single
// data-bus transactions, waits for the bus response with a timeout, and
// forms the writeback result. Non-memory ops and bubbles pass straight through.
// Faulted ops (misaligned or illegal funct3) never reach the bus.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | no bus access outstanding; decode and accept the next op
//   S_WAIT | request on the bus, waiting for dmem_ready or the timeout
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [31:0] mem_inst,
  input  logic [31:0] mem_result,
  input  logic [31:0] mem_wdata,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_inst,
  output logic [31:0] wb_result,
  output logic        wb_fault
);

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  // The counter holds the number of WAIT cycles already spent without
  // ready, so the current cycle is the TIMEOUT_CYCLES-th one when it
  // equals TIMEOUT_CYCLES-1.
  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] CNT_MAX   = 8'hFF;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] baddr_q, baddr_d;
  logic [2:0]  f3_q, f3_d;
  logic        load_q, load_d;
  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_inst_q, wb_inst_d;
  logic [31:0] wb_result_q, wb_result_d;
  logic        wb_fault_q, wb_fault_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [1:0]  lane;
  logic        is_load, is_store, is_mem;
  logic        f3_bad, misaligned, op_fault, op_go;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_data;

  // Decode the incoming instruction and classify it as go/fault/pass.
  always_comb begin
    opcode   = mem_inst[6:0];
    funct3   = mem_inst[14:12];
    lane     = mem_result[1:0];
    is_load  = mem_valid && (opcode == OPC_LOAD);
    is_store = mem_valid && (opcode == OPC_STORE);
    is_mem   = is_load || is_store;
    f3_bad   = 1'b0;
    if (is_load) begin
      f3_bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    end else if (is_store) begin
      f3_bad = funct3[2] || (funct3 == 3'b011);
    end
    // funct3[1:0] gives the access size for every legal load and store.
    unique case (funct3[1:0])
      2'b01:   misaligned = lane[0];
      2'b10:   misaligned = (lane != 2'b00);
      default: misaligned = 1'b0;
    endcase
    op_fault = is_mem && (f3_bad || misaligned);
    op_go    = is_mem && !op_fault;
  end

  // Byte enables and lane-replicated write data for the outgoing request.
  always_comb begin
    req_be    = 4'b1111;
    req_wdata = 32'h0;
    if (is_store) begin
      unique case (funct3[1:0])
        2'b00: begin
          req_be    = 4'b0001 << lane;
          req_wdata = {4{mem_wdata[7:0]}};
        end
        2'b01: begin
          req_be    = lane[1] ? 4'b1100 : 4'b0011;
          req_wdata = {2{mem_wdata[15:0]}};
        end
        default: begin
          req_be    = 4'b1111;
          req_wdata = mem_wdata;
        end
      endcase
    end
  end

  // Pick the addressed byte/half from the returned word and extend it.
  always_comb begin
    unique case (baddr_q[1:0])
      2'b00:   rd_byte = dmem_rdata[7:0];
      2'b01:   rd_byte = dmem_rdata[15:8];
      2'b10:   rd_byte = dmem_rdata[23:16];
      default: rd_byte = dmem_rdata[31:24];
    endcase
    rd_half = baddr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    unique case (f3_q)
      3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  load_data = {24'h0, rd_byte};
      3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_data = {16'h0, rd_half};
      default: load_data = dmem_rdata;
    endcase
  end

  // Next-state, bus request and writeback logic; stall is purely combinational.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    we_d        = we_q;
    be_d        = be_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    baddr_d     = baddr_q;
    f3_d        = f3_q;
    load_d      = load_q;
    wb_valid_d  = wb_valid_q;
    wb_inst_d   = wb_inst_q;
    wb_result_d = wb_result_q;
    wb_fault_d  = wb_fault_q;
    stall       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (op_go) begin
          stall      = 1'b1;
          req_d      = 1'b1;
          we_d       = is_store;
          be_d       = req_be;
          addr_d     = {mem_result[31:2], 2'b00};
          wdata_d    = req_wdata;
          baddr_d    = mem_result;
          f3_d       = funct3;
          load_d     = is_load;
          cnt_d      = 8'h0;
          wb_valid_d = 1'b0;
          state_d    = S_WAIT;
        end else if (op_fault) begin
          wb_valid_d  = 1'b1;
          wb_inst_d   = mem_inst;
          wb_result_d = mem_result;
          wb_fault_d  = 1'b1;
        end else begin
          wb_valid_d  = mem_valid;
          wb_inst_d   = mem_inst;
          wb_result_d = mem_result;
          wb_fault_d  = 1'b0;
        end
      end
      S_WAIT: begin
        stall = !dmem_ready;
        // Upstream is stalled while we wait, so mem_inst still belongs to this access.
        if (dmem_ready) begin
          req_d       = 1'b0;
          wb_valid_d  = 1'b1;
          wb_inst_d   = mem_inst;
          wb_result_d = load_q ? load_data : baddr_q;
          wb_fault_d  = 1'b0;
          state_d     = S_IDLE;
        end else if (cnt_q == TO_LAST) begin
          req_d       = 1'b0;
          wb_valid_d  = 1'b1;
          wb_inst_d   = mem_inst;
          wb_result_d = baddr_q;
          wb_fault_d  = 1'b1;
          state_d     = S_IDLE;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset abandons any outstanding access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'h0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      be_q        <= 4'h0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      baddr_q     <= 32'h0;
      f3_q        <= 3'h0;
      load_q      <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_inst_q   <= 32'h0;
      wb_result_q <= 32'h0;
      wb_fault_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      we_q        <= we_d;
      be_q        <= be_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      baddr_q     <= baddr_d;
      f3_q        <= f3_d;
      load_q      <= load_d;
      wb_valid_q  <= wb_valid_d;
      wb_inst_q   <= wb_inst_d;
      wb_result_q <= wb_result_d;
      wb_fault_q  <= wb_fault_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_be    = be_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_inst    = wb_inst_q;
  assign wb_result  = wb_result_q;
  assign wb_fault   = wb_fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a writeback scoreboard and a simple
// bus responder whose ready latency is set per operation.
module tb_mem_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_valid;
  logic [31:0] mem_inst, mem_result, mem_wdata;
  logic        stall;
  logic        dmem_req, dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;
  logic        wb_valid;
  logic [31:0] wb_inst, wb_result;
  logic        wb_fault;

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_inst(mem_inst), .mem_result(mem_result), .mem_wdata(mem_wdata),
    .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_inst(wb_inst), .wb_result(wb_result), .wb_fault(wb_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] result;
    logic        fault;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          tests = 0;
  int          fails = 0;
  int          ready_lat = 1;   // 0 = never ready
  logic [31:0] rdata_v = 32'h0;
  int          wait_cnt = 0;

  function automatic logic [31:0] ld(input logic [2:0] f3);
    return {17'd0, f3, 5'd5, 7'b0000011};
  endfunction

  function automatic logic [31:0] st(input logic [2:0] f3);
    return {17'd0, f3, 5'd0, 7'b0100011};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Bus responder: ready comes ready_lat cycles into the request.
  always @(negedge clk) begin
    if (dmem_req === 1'b1) begin
      wait_cnt++;
      dmem_ready = (ready_lat != 0) && (wait_cnt >= ready_lat);
    end else begin
      wait_cnt   = 0;
      dmem_ready = 1'b0;
    end
    dmem_rdata = rdata_v;
  end

  // Writeback monitor.
  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_wb: got inst 0x%08h result 0x%08h, expected no writeback", wb_inst, wb_result);
      end else begin
        mon_e = sb.pop_front();
        check("wb_inst", wb_inst, mon_e.inst);
        check("wb_result", wb_result, mon_e.result);
        check("wb_fault", {31'd0, wb_fault}, {31'd0, mon_e.fault});
      end
    end
  end

  task automatic run_op(input string name, input logic [31:0] inst, input logic [31:0] res,
                        input logic [31:0] wd, input logic [31:0] rd, input int lat,
                        input logic [31:0] exp_res, input logic exp_fault,
                        input int exp_reqs, input int exp_stalls,
                        input logic [31:0] exp_addr, input logic exp_we, input logic [3:0] exp_be,
                        input logic chk_wd, input logic [31:0] exp_wd);
    int   stalls = 0;
    int   reqs = 0;
    logic seen = 1'b0;
    logic done = 1'b0;
    mem_valid  = 1'b1;
    mem_inst   = inst;
    mem_result = res;
    mem_wdata  = wd;
    rdata_v    = rd;
    ready_lat  = lat;
    sb.push_back('{inst, exp_res, exp_fault});
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      #2;
      if (stall === 1'b1) stalls++;
      if (dmem_req === 1'b1) begin
        reqs++;
        if (!seen) begin
          seen = 1'b1;
          check({name, " addr"}, dmem_addr, exp_addr);
          check({name, " we"}, {31'd0, dmem_we}, {31'd0, exp_we});
          check({name, " be"}, {28'd0, dmem_be}, {28'd0, exp_be});
          if (chk_wd) check({name, " wdata"}, dmem_wdata, exp_wd);
        end
      end
      @(posedge clk);
      #1;
      if (wb_valid === 1'b1) done = 1'b1;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL %s: got no writeback within 64 cycles, expected one", name);
    end
    check({name, " req_cycles"}, 32'(reqs), 32'(exp_reqs));
    check({name, " stall_cycles"}, 32'(stalls), 32'(exp_stalls));
  endtask

  task automatic bubble(input logic [31:0] inst);
    mem_valid = 1'b0;
    mem_inst  = inst;
    @(negedge clk);
    #2;
    check("bubble stall", {31'd0, stall}, 32'd0);
    check("bubble dmem_req", {31'd0, dmem_req}, 32'd0);
    @(posedge clk);
    #1;
    check("bubble wb_valid", {31'd0, wb_valid}, 32'd0);
  endtask

  initial begin
    mem_valid  = 1'b0;
    mem_inst   = 32'h0;
    mem_result = 32'h0;
    mem_wdata  = 32'h0;
    #1 rst = 1'b1;
    #1;
    check("rst dmem_req", {31'd0, dmem_req}, 32'd0);
    check("rst dmem_we", {31'd0, dmem_we}, 32'd0);
    check("rst dmem_be", {28'd0, dmem_be}, 32'd0);
    check("rst dmem_addr", dmem_addr, 32'd0);
    check("rst dmem_wdata", dmem_wdata, 32'd0);
    check("rst wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst wb_inst", wb_inst, 32'd0);
    check("rst wb_result", wb_result, 32'd0);
    check("rst wb_fault", {31'd0, wb_fault}, 32'd0);
    check("rst stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    //     name    inst          addr          wdata         rdata         lat result        flt reqs stalls bus_addr     we  be       chkwd bus_wdata
    run_op("addi", 32'h02A00293, 32'h0000002A, 32'h0,        32'h0,        1, 32'h0000002A, 0, 0, 0, 32'h0,        0, 4'h0,    0, 32'h0);
    run_op("lb",   ld(3'b000),   32'h00000103, 32'h0,        32'h80FFFFFF, 2, 32'hFFFFFF80, 0, 2, 2, 32'h00000100, 0, 4'b1111, 0, 32'h0);
    run_op("lbu",  ld(3'b100),   32'h00000103, 32'h0,        32'h80FFFFFF, 2, 32'h00000080, 0, 2, 2, 32'h00000100, 0, 4'b1111, 0, 32'h0);
    run_op("sh",   st(3'b001),   32'h00000202, 32'h1234ABCD, 32'h0,        1, 32'h00000202, 0, 1, 1, 32'h00000200, 1, 4'b1100, 1, 32'hABCDABCD);
    run_op("lw_mis", ld(3'b010), 32'h00000301, 32'h0,        32'h0,        1, 32'h00000301, 1, 0, 0, 32'h0,        0, 4'h0,    0, 32'h0);
    run_op("sb",   st(3'b000),   32'h00001001, 32'h000000EF, 32'h0,        1, 32'h00001001, 0, 1, 1, 32'h00001000, 1, 4'b0010, 1, 32'hEFEFEFEF);
    run_op("lh",   ld(3'b001),   32'h00000402, 32'h0,        32'h80017FFF, 1, 32'hFFFF8001, 0, 1, 1, 32'h00000400, 0, 4'b1111, 0, 32'h0);
    run_op("lhu",  ld(3'b101),   32'h00000400, 32'h0,        32'h1234F00D, 3, 32'h0000F00D, 0, 3, 3, 32'h00000400, 0, 4'b1111, 0, 32'h0);
    run_op("lw",   ld(3'b010),   32'h00000500, 32'h0,        32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 1, 1, 32'h00000500, 0, 4'b1111, 0, 32'h0);
    run_op("ld_f3bad", ld(3'b011), 32'h00000600, 32'h0,      32'h0,        1, 32'h00000600, 1, 0, 0, 32'h0,        0, 4'h0,    0, 32'h0);
    run_op("st_f3bad", st(3'b011), 32'h00000604, 32'h0,      32'h0,        1, 32'h00000604, 1, 0, 0, 32'h0,        0, 4'h0,    0, 32'h0);
    run_op("sh_mis", st(3'b001), 32'h00000203, 32'h0,        32'h0,        1, 32'h00000203, 1, 0, 0, 32'h0,        0, 4'h0,    0, 32'h0);
    run_op("sw_timeout", st(3'b010), 32'h00000700, 32'h55AA55AA, 32'h0,    0, 32'h00000700, 1, 4, 5, 32'h00000700, 1, 4'b1111, 1, 32'h55AA55AA);
    bubble(32'h0);
    run_op("sw_ready_wins", st(3'b010), 32'h00000704, 32'h01234567, 32'h0, 4, 32'h00000704, 0, 4, 4, 32'h00000704, 1, 4'b1111, 1, 32'h01234567);
    bubble(ld(3'b010));

    // Reset in the middle of a WAIT cycle, then a fresh access.
    mem_valid  = 1'b1;
    mem_inst   = ld(3'b010);
    mem_result = 32'h00000800;
    ready_lat  = 0;
    @(posedge clk);
    #1;
    check("rstwait req_before", {31'd0, dmem_req}, 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rstwait dmem_req", {31'd0, dmem_req}, 32'd0);
    check("rstwait wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rstwait dmem_addr", dmem_addr, 32'd0);
    #1 rst = 1'b0;
    run_op("lw_after_rst", ld(3'b010), 32'h00000800, 32'h0, 32'h0BADF00D, 1, 32'h0BADF00D, 0, 1, 1, 32'h00000800, 0, 4'b1111, 0, 32'h0);
    bubble(32'h0);
    bubble(32'h0);
    check("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
